// File: rtl/axi_rd_responder.sv
// AXI4 read-only slave: accepts one AR burst at a time and streams R beats from a 1-cycle-latency memory.
// Define AXI_RD_WRAP_EN to build WRAP burst support; without it, WRAP requests run as INCR.
module axi_rd_responder #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_AW     = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AXI_araddr,
  input  logic [7:0]            S_AXI_arlen,
  input  logic [2:0]            S_AXI_arsize,
  input  logic [1:0]            S_AXI_arburst,
  input  logic [ID_WIDTH-1:0]   S_AXI_arid,
  input  logic [3:0]            S_AXI_arcache,
  input  logic                  S_AXI_arlock,
  input  logic [2:0]            S_AXI_arprot,
  input  logic [3:0]            S_AXI_arqos,
  input  logic                  S_AXI_arvalid,
  output logic                  S_AXI_arready,
  output logic [ID_WIDTH-1:0]   S_AXI_rid,
  output logic [DATA_WIDTH-1:0] S_AXI_rdata,
  output logic [1:0]            S_AXI_rresp,
  output logic                  S_AXI_rlast,
  output logic                  S_AXI_rvalid,
  input  logic                  S_AXI_rready,
  output logic                  mem_rd_en,
  output logic [MEM_AW-1:0]     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  localparam int L   = $clog2(DATA_WIDTH / 8);
  localparam int TOP = MEM_AW + L;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
`ifdef AXI_RD_WRAP_EN
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic                  alive_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [7:0]            len_reg;
  logic [1:0]            burst_reg;
  logic [1:0]            resp_reg;
  logic [MEM_AW-1:0]     addr_reg;
  logic [MEM_AW-1:0]     addr_next;
  logic [MEM_AW-1:0]     addr_inc;
  logic [8:0]            issue_idx_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic [DATA_WIDTH-1:0] fifo_data_reg [2];
  logic                  fifo_last_reg [2];
  logic                  wr_ptr_reg, rd_ptr_reg;
  logic [1:0]            count_reg, count_next;

  logic                  ar_hs;
  logic [MEM_AW-1:0]     ar_word;
  logic                  ar_high_nz;
  logic [1:0]            ar_resp;
  logic                  beats_left;
  logic                  issue_room;
  logic                  issue;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] ret_data;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic                  r_hs;
  logic                  push;
  logic                  pop;
  logic                  unused_ok;

  // Sideband AR fields and the byte-lane address bits carry no meaning here.
  assign unused_ok = ^{S_AXI_araddr, S_AXI_arcache, S_AXI_arlock, S_AXI_arprot, S_AXI_arqos};

  assign ar_word = S_AXI_araddr[TOP-1:L];

  generate
    if (ADDR_WIDTH > TOP) begin : g_high
      assign ar_high_nz = |S_AXI_araddr[ADDR_WIDTH-1:TOP];
    end else begin : g_no_high
      assign ar_high_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    ar_resp = RESP_OKAY;
    if (ar_high_nz) begin
      ar_resp = RESP_DECERR;
    end else if ((S_AXI_arsize != 3'(L)) || (S_AXI_arburst == 2'b11)) begin
      ar_resp = RESP_SLVERR;
    end
`ifdef AXI_RD_WRAP_EN
    else if ((S_AXI_arburst == BURST_WRAP) &&
             !(S_AXI_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
      ar_resp = RESP_SLVERR;
    end
`endif
  end

  assign addr_inc = addr_reg + MEM_AW'(1);

`ifdef AXI_RD_WRAP_EN
  logic [MEM_AW-1:0] wrap_mask;
  assign wrap_mask = MEM_AW'(len_reg);
`endif

  always_comb begin
    addr_next = addr_inc;
    if (burst_reg == BURST_FIXED) begin
      addr_next = addr_reg;
    end
`ifdef AXI_RD_WRAP_EN
    else if (burst_reg == BURST_WRAP) begin
      addr_next = (addr_reg & ~wrap_mask) | (addr_inc & wrap_mask);
    end
`endif
  end

  // Keep buffered plus in-flight beats at most 2 so a returning read always has a slot.
  assign ar_hs      = S_AXI_arvalid && S_AXI_arready;
  assign beats_left = issue_idx_reg <= {1'b0, len_reg};
  assign issue_room = (count_reg == 2'd0) || ((count_reg == 2'd1) && !inflight_reg);
  assign issue      = (state_reg == S_BURST) && beats_left && issue_room;

  assign mem_rd_en   = issue && (resp_reg == RESP_OKAY);
  assign mem_rd_addr = addr_reg;

  // An empty FIFO lets the returning beat straight onto R, saving a cycle of latency.
  assign fifo_empty = (count_reg == 2'd0);
  assign ret_data   = (resp_reg == RESP_OKAY) ? mem_rd_data : '0;
  assign head_data  = fifo_empty ? ret_data : fifo_data_reg[rd_ptr_reg];
  assign head_last  = fifo_empty ? inflight_last_reg : fifo_last_reg[rd_ptr_reg];

  assign S_AXI_arready = (state_reg == S_IDLE) && alive_reg;
  assign S_AXI_rvalid  = !fifo_empty || inflight_reg;
  assign S_AXI_rdata   = S_AXI_rvalid ? head_data : '0;
  assign S_AXI_rlast   = S_AXI_rvalid && head_last;
  assign S_AXI_rid     = id_reg;
  assign S_AXI_rresp   = resp_reg;

  assign r_hs = S_AXI_rvalid && S_AXI_rready;
  assign pop  = r_hs && !fifo_empty;
  assign push = inflight_reg && !(r_hs && fifo_empty);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ar_hs) state_next = S_BURST;
      S_BURST: if (r_hs && S_AXI_rlast) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg         <= S_IDLE;
      alive_reg         <= 1'b0;
      id_reg            <= '0;
      len_reg           <= '0;
      burst_reg         <= '0;
      resp_reg          <= RESP_OKAY;
      addr_reg          <= '0;
      issue_idx_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      count_reg         <= '0;
    end else begin
      state_reg    <= state_next;
      alive_reg    <= 1'b1;
      inflight_reg <= issue;
      count_reg    <= count_next;
      if (issue) begin
        inflight_last_reg <= (issue_idx_reg[7:0] == len_reg);
      end
      if (ar_hs) begin
        id_reg        <= S_AXI_arid;
        len_reg       <= S_AXI_arlen;
        burst_reg     <= S_AXI_arburst;
        resp_reg      <= ar_resp;
        addr_reg      <= ar_word;
        issue_idx_reg <= '0;
      end else if (issue) begin
        addr_reg      <= addr_next;
        issue_idx_reg <= issue_idx_reg + 9'd1;
      end
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Payload storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_data_reg[wr_ptr_reg] <= ret_data;
      fifo_last_reg[wr_ptr_reg] <= inflight_last_reg;
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Scoreboard bench for axi_rd_responder: a burst-level reference model fills an expected-beat queue
// and an independent R-channel monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_axi_rd_responder;
  localparam int DW  = 256;
  localparam int AW  = 32;
  localparam int IW  = 4;
  localparam int MAW = 10;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic [AW-1:0]   S_AXI_araddr = '0;
  logic [7:0]      S_AXI_arlen = '0;
  logic [2:0]      S_AXI_arsize = '0;
  logic [1:0]      S_AXI_arburst = '0;
  logic [IW-1:0]   S_AXI_arid = '0;
  logic [3:0]      S_AXI_arcache = '0;
  logic            S_AXI_arlock = 1'b0;
  logic [2:0]      S_AXI_arprot = '0;
  logic [3:0]      S_AXI_arqos = '0;
  logic            S_AXI_arvalid = 1'b0;
  logic            S_AXI_arready;
  logic [IW-1:0]   S_AXI_rid;
  logic [DW-1:0]   S_AXI_rdata;
  logic [1:0]      S_AXI_rresp;
  logic            S_AXI_rlast;
  logic            S_AXI_rvalid;
  logic            S_AXI_rready = 1'b0;
  logic            mem_rd_en;
  logic [MAW-1:0]  mem_rd_addr;
  logic [DW-1:0]   mem_rd_data = '0;

  axi_rd_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_AW(MAW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen), .S_AXI_arsize(S_AXI_arsize),
    .S_AXI_arburst(S_AXI_arburst), .S_AXI_arid(S_AXI_arid), .S_AXI_arcache(S_AXI_arcache),
    .S_AXI_arlock(S_AXI_arlock), .S_AXI_arprot(S_AXI_arprot), .S_AXI_arqos(S_AXI_arqos),
    .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rid(S_AXI_rid), .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
    .S_AXI_rlast(S_AXI_rlast), .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 ACLK = ~ACLK;

  logic [DW-1:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 1);
  always @(posedge ACLK) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc, first_rv_cyc, last_rv_cyc, first_rd_cyc, rd_cnt, rv_cnt;
  int rr_mode = 0;  // 0: rready high, 1: random, 2: held low

  always @(posedge ACLK) cyc <= cyc + 1;

  initial forever begin
    @(posedge ACLK);
    #1;
    case (rr_mode)
      0:       S_AXI_rready = 1'b1;
      1:       S_AXI_rready = 1'($urandom_range(0, 1));
      default: S_AXI_rready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got id=%0h resp=%0d last=%0b data=%0h expected id=%0h resp=%0d last=%0b data=%0h",
               name, act.id, act.resp, act.last, act.data, exp.id, exp.resp, exp.last, exp.data);
    end
  endtask

  // Reference model: derive every beat of a burst straight from the AXI address rules.
  function automatic int model_burst(input logic [31:0] addr, input int len, input int size,
                                     input int burst, input int id);
    int resp, word, w;
    beat_t b;
    resp = 0;
    if ((addr >> 15) != 0) resp = 3;
    else if (size != 5 || burst == 3) resp = 2;
`ifdef AXI_RD_WRAP_EN
    else if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) resp = 2;
`endif
    word = int'((addr / 32) % 1024);
    for (int i = 0; i <= len; i++) begin
      if (burst == 0) w = word;
`ifdef AXI_RD_WRAP_EN
      else if (burst == 2) begin
        int base;
        base = word - (word % (len + 1));
        w = base + ((word - base + i) % (len + 1));
      end
`endif
      else w = (word + i) % 1024;
      b.id   = IW'(id);
      b.data = (resp == 0) ? DW'(w + 1) : '0;
      b.resp = 2'(resp);
      b.last = (i == len);
      exp_q.push_back(b);
    end
    return resp;
  endfunction

  // R-channel monitor
  bit    hold_pending = 0;
  bit    ar_chk = 0;
  beat_t held;

  always @(negedge ARESETN) begin
    hold_pending = 0;
    ar_chk = 0;
  end

  always @(negedge ACLK) begin
    beat_t cur;
    if (!ARESETN) begin
      hold_pending = 0;
      ar_chk = 0;
    end else begin
      if (ar_chk) begin
        chk("arready_after_rlast", S_AXI_arready, 1);
        ar_chk = 0;
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      cur.id = S_AXI_rid; cur.data = S_AXI_rdata; cur.resp = S_AXI_rresp; cur.last = S_AXI_rlast;
      if (S_AXI_rvalid) begin
        rv_cnt++;
        if (first_rv_cyc < 0) first_rv_cyc = cyc;
        last_rv_cyc = cyc;
        chk("arready_busy", S_AXI_arready, 0);
        if (hold_pending) chk_beat("r_hold_stable", cur, held);
        if (S_AXI_rready) begin
          hold_pending = 0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_beat: got id=%0h data=%0h, expected no beat", cur.id, cur.data);
          end else begin
            chk_beat("beat", cur, exp_q.pop_front());
          end
          if (cur.last) ar_chk = 1;
        end else begin
          hold_pending = 1;
          held = cur;
        end
      end else if (hold_pending) begin
        n_cmp++; n_bad++;
        $display("FAIL rvalid_drop: got rvalid=0 expected 1 until handshake");
        hold_pending = 0;
      end
    end
  end

  task automatic pulse_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    exp_q.delete();
    ARESETN = 1'b1;
  endtask

  task automatic do_ar(input logic [31:0] addr, input int len, input int size, input int burst,
                       input int id, output int resp, output bit ok);
    int g;
    g = 0;
    resp = 0;
    @(negedge ACLK);
    S_AXI_araddr = addr; S_AXI_arlen = 8'(len); S_AXI_arsize = 3'(size);
    S_AXI_arburst = 2'(burst); S_AXI_arid = IW'(id); S_AXI_arvalid = 1'b1;
    while (!S_AXI_arready && g < 100) begin
      @(negedge ACLK);
      g++;
    end
    ok = S_AXI_arready;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL ar_accept: got arready=0 for 100 cycles expected 1");
      S_AXI_arvalid = 1'b0;
      return;
    end
    hs_cyc = cyc + 1;
    first_rv_cyc = -1; last_rv_cyc = -1; first_rd_cyc = -1; rd_cnt = 0; rv_cnt = 0;
    resp = model_burst(addr, len, size, burst, id);
    @(posedge ACLK);
    #1;
    S_AXI_arvalid = 1'b0;
  endtask

  // rand_cyc: 0 keeps rready high; otherwise rready is random for that many cycles, then high.
  task automatic run_burst(input logic [31:0] addr, input int len, input int size, input int burst,
                           input int id, input int rand_cyc);
    int resp, g;
    bit ok;
    rr_mode = (rand_cyc > 0) ? 1 : 0;
    do_ar(addr, len, size, burst, id, resp, ok);
    if (!ok) begin
      rr_mode = 0;
      exp_q.delete();
      pulse_reset();
      return;
    end
    g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge ACLK);
      g++;
      if (g == rand_cyc) rr_mode = 0;
    end
    rr_mode = 0;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL burst_timeout: got %0d beats outstanding expected 0", exp_q.size());
      pulse_reset();
      return;
    end
    chk_int("mem_reads", rd_cnt, (resp == 0) ? len + 1 : 0);
    chk_int("rvalid_latency", first_rv_cyc - hs_cyc, 1);
    if (resp == 0) chk_int("rd_en_latency", first_rd_cyc - hs_cyc, 0);
    if (rand_cyc == 0) chk_int("back_to_back_span", last_rv_cyc - first_rv_cyc + 1, len + 1);
    $display("burst id=%0d addr=%08h len=%0d type=%0d size=%0d resp=%0d rvalid_cycles=%0d",
             id, addr, len, burst, size, resp, rv_cnt);
  endtask

  initial begin
    int resp, g;
    bit ok;

    repeat (3) @(negedge ACLK);
    chk("rst_arready", S_AXI_arready, 0);
    chk("rst_rvalid", S_AXI_rvalid, 0);
    chk("rst_rlast", S_AXI_rlast, 0);
    chk("rst_rid", S_AXI_rid, 0);
    chk("rst_rresp", S_AXI_rresp, 0);
    chk("rst_rdata", S_AXI_rdata, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    ARESETN = 1'b1;
    #1 chk("arready_before_edge", S_AXI_arready, 0);
    @(negedge ACLK);
    chk("arready_first_edge", S_AXI_arready, 1);

    run_burst(32'h0000_0000, 0, 5, 1, 1, 0);
    run_burst(32'h0000_0000, 3, 5, 1, 2, 0);
    run_burst(32'h0000_0000, 7, 5, 1, 3, 30);
    run_burst(32'h0000_00A0, 2, 5, 0, 6, 0);
    run_burst(32'h0000_0040, 3, 5, 2, 7, 0);
    run_burst(32'h0000_8000, 3, 5, 1, 8, 0);
    run_burst(32'h0000_0000, 3, 3, 1, 9, 0);
    run_burst(32'h0000_7D00, 255, 5, 1, 10, 0);

    // Abort a burst with one beat on R and one read in flight.
    rr_mode = 2;
    do_ar(32'h0000_0000, 7, 5, 1, 4, resp, ok);
    @(negedge ACLK);
    @(negedge ACLK);
    chk("abort_rvalid_before", S_AXI_rvalid, 1);
    chk("abort_rd_en_before", mem_rd_en, 1);
    ARESETN = 1'b0;
    #1;
    chk("abort_rvalid_now", S_AXI_rvalid, 0);
    chk("abort_mem_rd_en_now", mem_rd_en, 0);
    chk("abort_arready_now", S_AXI_arready, 0);
    exp_q.delete();
    #2 ARESETN = 1'b1;
    rr_mode = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("abort_no_stray_beat", S_AXI_rvalid, 0);
    end
    run_burst(32'h0000_0140, 4, 5, 1, 11, 0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int ln, sz, bu, id, rc, r;
      a = {17'd0, 10'($urandom_range(0, 1023)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 7) == 0) a[31:15] = 17'($urandom_range(1, 131071));
      r = $urandom_range(0, 9);
      if (r == 0) ln = 255;
      else if (r < 4) ln = (2 << $urandom_range(0, 3)) - 1;
      else ln = $urandom_range(0, 20);
      sz = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 5;
      bu = $urandom_range(0, 3);
      id = $urandom_range(0, 15);
      rc = ($urandom_range(0, 2) == 0) ? 0 : 100000;
      run_burst(a, ln, sz, bu, id, rc);
    end

    repeat (3) @(negedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
